ice40_watchdog: RTL and testbench
=================================

# ice40_watchdog

Watchdog timer that raises a registered, active-high reset request when software fails to kick it in time. It is the initiator side of the system reset path: its `wdt_reset` output feeds the reset generator's request input, and the generator turns it into the SoC-wide reset. The block itself is reset only by the power-on reset, so its sticky `fired` flag survives the watchdog-initiated reset and can be read afterwards.

## Interface
Parameters:
- `CNT_W`, 16: width of the timeout counter and of the `timeout` and `warn_at` inputs.
- `PULSE_LEN`, 16: number of cycles `wdt_reset` is held high per expiry. Legal range is 1..255.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high. Driven from the power-on reset only, never from `wdt_reset`.
- `enable`, in, 1: level input. 1 = watchdog armed.
- `kick`, in, 1: one-cycle strobe that reloads the counter.
- `timeout`, in, `CNT_W`: reload value in cycles.
- `warn_at`, in, `CNT_W`: `warn` asserts when the count is ≤ this value.
- `clr_fired`, in, 1: clears the sticky `fired` flag.
- `wdt_reset`, out, 1: reset request to the reset generator. Registered.
- `warn`, out, 1: early-warning level. Registered.
- `fired`, out, 1: sticky expiry flag.
- `count`, out, `CNT_W`: current counter value.

## Operation
- **States:**
  - `IDLE`: counter not running.
  - `RUN`: counting down.
  - `WARN`: counting down with `warn=1`.
  - `FIRE`: `wdt_reset=1`, pulse counter running.
- **Reset values:** state=`IDLE`, `count`=0, `wdt_reset`=0, `warn`=0, `fired`=0, pulse counter=0.
- **`IDLE` → `RUN`:** when `enable`=1. The counter loads `max(timeout,1)`; `timeout`=0 is treated as 1.
- **Counting (`RUN`/`WARN`):**
  - `kick`=1: reload with `max(timeout,1)`.
  - Otherwise, if `count`>0: decrement.
  - `timeout` and `warn_at` are sampled only at load/reload. Changes mid-count have no effect until the next reload.
- **`RUN` ↔ `WARN`:** the state is `WARN` whenever the next `count` ≤ `warn_at`, otherwise `RUN`. `warn` = (state==`WARN`). With `warn_at` ≥ reload value, `warn` is high from the load cycle.
- **Expiry:** in `RUN`/`WARN` with `count`==0 and `kick`=0:
  - Go to `FIRE`.
  - `wdt_reset`←1, `fired`←1, pulse counter←`PULSE_LEN`-1, `warn`←0.
- **`FIRE`:**
  - Pulse counter decrements each cycle. `kick` and `enable` are ignored, so the pulse always completes.
  - When the pulse counter reaches 0, `wdt_reset`←0.
  - Next state is `RUN` with reload if `enable`=1, else `IDLE`.
- **`enable` low in `RUN`/`WARN`:** go to `IDLE`, `count`←0, `warn`←0. No request is issued.
- **Simultaneous events:**
  - `kick` in the same cycle that `count`==0: `kick` wins and no expiry occurs.
  - `clr_fired` in the same cycle as expiry: set wins and `fired`=1.
- **`fired`:** cleared only by `clr_fired` or `reset`.
- **`reset` mid-`FIRE`:** `wdt_reset` drops on the next edge and the state returns to `IDLE`.

## Timing
- Single-cycle decisions. All outputs are registered, with zero combinational path from inputs to outputs.
- **Arming:** `enable` sampled high at edge E → `count`=T after E.
- **Expiry latency:** with no kick, `count`=0 after E+T and `wdt_reset`=1 after E+T+1. Latency is T+1 cycles from the arming edge.
- **Kick:** `kick` at edge K gives `count`=T after K. The next expiry is at K+T+1 unless kicked again.
- **Pulse width:** `wdt_reset` is high for exactly `PULSE_LEN` consecutive cycles.
- **Restart after a pulse:** the first reload occurs on the edge that drops `wdt_reset`.
- **Counter arithmetic:** `count` never underflows; decrement is gated by `count`>0. The pulse counter is 8 bits.

## Structure
- **Shared package `ice40_wdt_pkg`:**
  - State enum `wdt_state_t` (`IDLE`/`RUN`/`WARN`/`FIRE`).
  - `PULSE_CNT_W`=8.
- **Sub-module `wdt_pulse_stretch`:** natural split for the `FIRE` pulse counter. Load strobe in, registered level out of `PULSE_LEN` cycles.
- **Top level:** the FSM and down-counter stay in `ice40_watchdog`.

## Test plan
- **Basic expiry:** `timeout`=10, `warn_at`=3, `PULSE_LEN`=4, `enable` held, no kicks.
  - `warn` rises when `count`=3.
  - `wdt_reset`=1 exactly 11 cycles after the arming edge, for 4 cycles.
  - `fired`=1; `warn`=0 during `FIRE`.
- **Periodic kick:** kick every 8 cycles with `timeout`=10.
  - `wdt_reset` never asserts.
  - `count` never drops below 2; `warn` asserts (count ≤ 3) but never `FIRE`.
- **Kick at zero:** kick on the exact cycle `count`=0 → no expiry; `count`=10 next cycle.
- **`timeout`=0:**
  - Behaves as 1, so `wdt_reset` is asserted 2 cycles after arming.
  - Change `timeout` 10→20 mid-run: takes effect only at the next kick.
- **Disable and ignored inputs:**
  - `enable` dropped at `count`=5 → `IDLE`, `count`=0, no request.
  - `enable` dropped during `FIRE` → the full `PULSE_LEN` pulse still completes, then `IDLE`.
  - `kick` during `FIRE` is ignored.
- **Sticky flag and reset:**
  - `fired` stays 1 through and after the pulse.
  - `clr_fired` coincident with an expiry edge leaves `fired`=1.
  - `reset` asserted mid-`FIRE` → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ice40_wdt_pkg.sv
// Shared types and constants for the ice40 watchdog timer.
`timescale 1ns/1ps
package ice40_wdt_pkg;

  localparam int PULSE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    FIRE = 2'd3
  } wdt_state_t;

endpackage

// File: rtl/wdt_pulse_stretch.sv
// Turns a one-cycle load strobe into a registered level exactly PULSE_LEN cycles wide.
`timescale 1ns/1ps
module wdt_pulse_stretch
  import ice40_wdt_pkg::*;
#(
  parameter int PULSE_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic pulse,
  output logic last
);

  localparam logic [PULSE_CNT_W-1:0] LOAD_VAL = PULSE_CNT_W'(PULSE_LEN - 1);
  localparam logic [PULSE_CNT_W-1:0] ONE      = PULSE_CNT_W'(1);

  logic [PULSE_CNT_W-1:0] pcnt;

  // The level drops on the edge after the counter has reached zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= 1'b0;
      pcnt  <= '0;
    end else if (load) begin
      pulse <= 1'b1;
      pcnt  <= LOAD_VAL;
    end else if (pulse) begin
      if (pcnt == '0) begin
        pulse <= 1'b0;
      end else begin
        pcnt <= pcnt - ONE;
      end
    end
  end

  assign last = pulse && (pcnt == '0);

endmodule

// File: rtl/ice40_watchdog.sv
// Watchdog timer: down-counter plus FSM that issues a fixed-width reset request
// when software fails to kick in time, with a sticky fired flag.
`timescale 1ns/1ps
module ice40_watchdog
  import ice40_wdt_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PULSE_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             kick,
  input  logic [CNT_W-1:0] timeout,
  input  logic [CNT_W-1:0] warn_at,
  input  logic             clr_fired,
  output logic             wdt_reset,
  output logic             warn,
  output logic             fired,
  output logic [CNT_W-1:0] count,
  output wdt_state_t       state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  wdt_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] warn_lim_q, warn_lim_d;
  logic [CNT_W-1:0] reload_val;
  logic             fired_q;
  logic             counting;
  logic             expire;
  logic             load;
  logic             pulse_level;
  logic             pulse_last;

  assign reload_val = (timeout == '0) ? ONE : timeout;
  assign counting   = (state_q == RUN) || (state_q == WARN);
  // Kick beats a zero count, and a low enable suppresses the request entirely.
  assign expire     = counting && enable && !kick && (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      warn_lim_q <= '0;
      fired_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      warn_lim_q <= warn_lim_d;
      if (expire) begin
        fired_q <= 1'b1;
      end else if (clr_fired) begin
        fired_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    warn_lim_d = warn_lim_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) load = 1'b1;
      end
      RUN, WARN: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
        end else if (kick) begin
          load = 1'b1;
        end else if (expire) begin
          state_d = FIRE;
        end else begin
          count_d = count_q - ONE;
          state_d = ((count_q - ONE) <= warn_lim_q) ? WARN : RUN;
        end
      end
      FIRE: begin
        if (pulse_last) begin
          if (enable) load = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // timeout and warn_at only matter at the instant of a (re)load.
    if (load) begin
      count_d    = reload_val;
      warn_lim_d = warn_at;
      state_d    = (reload_val <= warn_at) ? WARN : RUN;
    end
  end

  always_comb begin
    warn  = (state_q == WARN);
    fired = fired_q;
    count = count_q;
    state = state_q;
  end

  wdt_pulse_stretch #(
    .PULSE_LEN(PULSE_LEN)
  ) u_pulse (
    .clk  (clk),
    .reset(reset),
    .load (expire),
    .pulse(pulse_level),
    .last (pulse_last)
  );

  assign wdt_reset = pulse_level;

endmodule

// File: tb/tb_ice40_watchdog.sv
// Directed bench for ice40_watchdog: the driver pushes the expected post-edge outputs
// for each cycle, and a monitor pops and compares them just after the edge.
`timescale 1ns/1ps
module tb_ice40_watchdog;
  import ice40_wdt_pkg::*;

  localparam int CNT_W = 16;
  localparam int PL    = 4;
  localparam logic [3:0] ALL = 4'hF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             kick = 1'b0;
  logic             clr_fired = 1'b0;
  logic [CNT_W-1:0] timeout = '0;
  logic [CNT_W-1:0] warn_at = '0;
  logic             wdt_reset, warn, fired;
  logic [CNT_W-1:0] count;
  wdt_state_t       state;

  ice40_watchdog #(.CNT_W(CNT_W), .PULSE_LEN(PL)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .kick     (kick),
    .timeout  (timeout),
    .warn_at  (warn_at),
    .clr_fired(clr_fired),
    .wdt_reset(wdt_reset),
    .warn     (warn),
    .fired    (fired),
    .count    (count),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       mask;
    logic [CNT_W-1:0] count;
    logic             rst;
    logic             warn;
    logic             fired;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string nm, input string fld, input logic [CNT_W-1:0] got,
                     input logic [CNT_W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s.%s got=%0d expected=%0d at %0t", nm, fld, got, want, $time);
    end
  endtask

  // One clock cycle: kick strobe k, expected outputs after the edge.
  task automatic cyc(input string nm, input logic k, input logic [3:0] m,
                     input logic [CNT_W-1:0] c, input logic r, input logic w, input logic f);
    exp_t e;
    kick    = k;
    e.mask  = m;
    e.count = c;
    e.rst   = r;
    e.warn  = w;
    e.fired = f;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
    kick = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.mask[0]) chk(nm, "count", count, e.count);
      if (e.mask[1]) chk(nm, "wdt_reset", CNT_W'(wdt_reset), CNT_W'(e.rst));
      if (e.mask[2]) chk(nm, "warn", CNT_W'(warn), CNT_W'(e.warn));
      if (e.mask[3]) chk(nm, "fired", CNT_W'(fired), CNT_W'(e.fired));
    end
  end

  initial begin
    logic [CNT_W-1:0] c;
    logic r, w, f;

    reset = 1'b1;
    cyc("reset", 1'b0, ALL, 0, 0, 0, 0);
    cyc("reset", 1'b0, ALL, 0, 0, 0, 0);
    reset = 1'b0;
    cyc("idle", 1'b0, ALL, 0, 0, 0, 0);

    // Basic expiry: arm at k=0, request on k=11..14, reload on k=15.
    timeout = 10; warn_at = 3; enable = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      c = (k <= 10) ? CNT_W'(10 - k) : ((k == 15) ? CNT_W'(10) : CNT_W'(0));
      r = (k >= 11) && (k <= 14);
      w = (k <= 10) && ((10 - k) <= 3);
      f = (k >= 11);
      cyc("basic", 1'b0, ALL, c, r, w, f);
    end
    enable = 1'b0;
    cyc("disable", 1'b0, ALL, 0, 0, 0, 1);
    clr_fired = 1'b1;
    cyc("clr_fired", 1'b0, ALL, 0, 0, 0, 0);
    clr_fired = 1'b0;

    // Periodic kick every 8 cycles.
    enable = 1'b1;
    cyc("kick_arm", 1'b0, ALL, 10, 0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      for (int j = 1; j <= 8; j++) begin
        c = (j == 8) ? CNT_W'(10) : CNT_W'(10 - j);
        cyc("periodic", (j == 8), ALL, c, 0, (j == 7), 0);
      end
    end

    // Kick on the exact cycle the count is zero.
    for (int j = 1; j <= 10; j++) begin
      cyc("zero_run", 1'b0, ALL, CNT_W'(10 - j), 0, ((10 - j) <= 3), 0);
    end
    cyc("kick_zero", 1'b1, ALL, 10, 0, 0, 0);
    cyc("after_kick_zero", 1'b0, ALL, 9, 0, 0, 0);
    enable = 1'b0;
    cyc("off", 1'b0, ALL, 0, 0, 0, 0);

    // timeout=0 acts as 1; clr_fired on the expiry edge; enable drop and kick in FIRE.
    timeout = 0; enable = 1'b1;
    cyc("t0_arm", 1'b0, ALL, 1, 0, 1, 0);
    cyc("t0_zero", 1'b0, ALL, 0, 0, 1, 0);
    clr_fired = 1'b1;
    cyc("t0_fire_clr", 1'b0, ALL, 0, 1, 0, 1);
    clr_fired = 1'b0;
    enable = 1'b0;
    cyc("fire_kick", 1'b1, ALL, 0, 1, 0, 1);
    cyc("fire_off", 1'b0, ALL, 0, 1, 0, 1);
    cyc("fire_off", 1'b0, ALL, 0, 1, 0, 1);
    cyc("fire_end", 1'b0, ALL, 0, 0, 0, 1);
    cyc("idle_after", 1'b0, ALL, 0, 0, 0, 1);
    clr_fired = 1'b1;
    cyc("clr2", 1'b0, ALL, 0, 0, 0, 0);
    clr_fired = 1'b0;

    // Mid-run timeout/warn_at changes only land at a reload; drop enable at count 5.
    timeout = 10; warn_at = 3; enable = 1'b1;
    cyc("mid_arm", 1'b0, ALL, 10, 0, 0, 0);
    cyc("mid_run", 1'b0, ALL, 9, 0, 0, 0);
    cyc("mid_run", 1'b0, ALL, 8, 0, 0, 0);
    cyc("mid_run", 1'b0, ALL, 7, 0, 0, 0);
    timeout = 20;
    cyc("mid_change", 1'b0, ALL, 6, 0, 0, 0);
    cyc("mid_kick", 1'b1, ALL, 20, 0, 0, 0);
    warn_at = 30;
    cyc("mid_after", 1'b0, ALL, 19, 0, 0, 0);
    cyc("mid_after", 1'b0, ALL, 18, 0, 0, 0);
    for (int j = 8; j <= 20; j++) begin
      cyc("mid_count", 1'b0, ALL, CNT_W'(25 - j), 0, 0, 0);
    end
    enable = 1'b0;
    cyc("drop_at5", 1'b0, ALL, 0, 0, 0, 0);
    cyc("drop_idle", 1'b0, ALL, 0, 0, 0, 0);

    // Power-on reset in the middle of a pulse.
    warn_at = 3; timeout = 0; enable = 1'b1;
    cyc("r_arm", 1'b0, ALL, 1, 0, 1, 0);
    cyc("r_zero", 1'b0, ALL, 0, 0, 1, 0);
    cyc("r_fire", 1'b0, ALL, 0, 1, 0, 1);
    cyc("r_fire2", 1'b0, ALL, 0, 1, 0, 1);
    reset = 1'b1;
    cyc("reset_mid_fire", 1'b0, ALL, 0, 0, 0, 0);
    reset = 1'b0; enable = 1'b0;
    cyc("post_reset", 1'b0, ALL, 0, 0, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
